inst_fetch_pair: RTL and testbench
==================================

// Module: inst_fetch_pair
// PURPOSE
//  Instruction fetch stage directly upstream of the dual-slot instruction buffer.
//  Holds the fetch PC and issues one 64-bit aligned request per fetch on the sram-like inst bus.
//  Writes up to two instructions (with their PCs and valid bits) into the buffer per returned beat.
//  Honours buffer back-pressure and branch/exception redirects, discarding stale in-flight data.
// PARAMETERS
//  RESET_PC   32'hBFC0_0000   fetch PC loaded on reset
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  redirect_i      in   1   branch/exception redirect; also flushes the buffer this cycle
//  redirect_pc_i   in   32  redirect target, word aligned
//  buffer_full_i   in   1   buffer cannot accept a further pair; blocks new requests
//  inst_req        out  1   request valid; held until inst_addr_ok
//  inst_addr       out  32  {pc[31:3],3'b000}
//  inst_addr_ok    in   1   request accepted
//  inst_data_ok    in   1   read data returned (one beat per accepted request, in order)
//  inst_rdata      in   64  [31:0]=word at +0, [63:32]=word at +4
//  inst1_o/inst2_o           out 32  instruction pair to buffer
//  inst1_addr_o/inst2_addr_o out 32  PCs of pair
//  inst1_valid_o/inst2_valid_o out 1 slot valid; one-cycle pulse per beat
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, inst_req=0, all *_valid_o=0, data/addr outputs=0.
//  States: IDLE, REQ, WAIT, CANCEL. can_fetch = !buffer_full_i & !redirect_i.
//  IDLE: can_fetch -> REQ; else stay.
//  REQ: inst_req=1, inst_addr from pc; addr_ok -> WAIT. Address/req stable until addr_ok,
//   except redirect (pc retargeted, new addr next cycle; request not yet accepted).
//  WAIT: data_ok -> capture beat; next state REQ if can_fetch else IDLE; pc <= {pc[31:3]+1,3'b000}.
//  CANCEL: data_ok -> drop beat -> IDLE. Redirect here: update pc, stay CANCEL.
//  Redirect in REQ with addr_ok same cycle, or in WAIT without data_ok -> CANCEL.
//  Redirect in WAIT with data_ok same cycle -> beat dropped, IDLE. Redirect always wins: pc<=redirect_pc_i.
//  Output registers: loaded the cycle after data_ok (latency 1). inst1_valid_o=!pc[2],
//   inst2_valid_o=1, inst1_addr_o={pc[31:3],3'b000}, inst2_addr_o=that+4. Valids clear the next cycle.
//  Unaligned entry (pc[2]=1): only slot 2 valid; the pair stays split (inst2_valid_o=1, inst1_valid_o=0).
//  redirect_i forces *_valid_o=0 next cycle (never writes a pair into a flushed buffer).
//  buffer_full_i sampled only at request launch; buffer asserts it with >=2 entries slack for the
//   one in-flight beat. At most one outstanding request ever.
//  rst mid-request: state IDLE immediately; the memory-side bridge is reset by the same rst.
// CONFIGURATION
//  FETCH_PERF_CNT_EN defined: adds out port perf_stall_cnt_o[31:0] (cycles in IDLE with
//   buffer_full_i=1) and perf_cancel_cnt_o[31:0] (beats dropped); both saturating, cleared by rst.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Shared defines header: state encodings, RESET_PC default, InstBus/InstAddrBus widths, Valid/Invalid.
//  Single module; no sub-module.
// TESTING
//  Reset, buffer_full_i=0, addr_ok/data_ok next cycle -> inst_addr=BFC00000, outputs pair
//   BFC00000/BFC00004 both valid, then request BFC00008.
//  Redirect to 0x8000_0014 while in WAIT, data_ok 3 cycles later -> beat dropped, next req
//   addr 0x8000_0010, only inst2_valid_o=1 with inst2_addr_o=0x8000_0014.
//  Redirect same cycle as data_ok -> no valid output next cycle, next req at target.
//  buffer_full_i=1 from IDLE -> inst_req stays 0; deassert -> req within 1 cycle, PC unchanged.
//  addr_ok withheld 5 cycles -> inst_req/inst_addr constant throughout.
//  FETCH_PERF_CNT_EN: 4 full cycles + 1 cancel -> stall cnt 4, cancel cnt 1.

Source files
------------

// File: rtl/inst_fetch_pair_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, reset PC,
// valid levels, FSM state encodings and the pair-alignment helper.
// No ports; imported by inst_fetch_pair.
package inst_fetch_pair_pkg;

   localparam int INST_BUS_W      = 64;
   localparam int INST_ADDR_W     = 32;

   localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

   localparam logic VALID   = 1'b1;
   localparam logic INVALID = 1'b0;

   // Legacy-compatible state constants.
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_REQ    = 2'd1;
   localparam logic [1:0] S_WAIT   = 2'd2;
   localparam logic [1:0] S_CANCEL = 2'd3;

   // Base address of the 64-bit pair containing the given word PC.
   function automatic logic [INST_ADDR_W-1:0] pair_base(input logic [INST_ADDR_W-1:2] pc);
      return {pc[INST_ADDR_W-1:3], 3'b000};
   endfunction

endpackage

// File: rtl/inst_fetch_pair.sv
// Purpose : fetch PC owner; one 64-bit aligned request per fetch, writes up to two
//           instructions (PCs + valids) into the dual-slot buffer per returned beat.
// Latency : pair outputs registered, valid the cycle after inst_data_ok (1-cycle pulse).
// Backpr. : buffer_full_i blocks launching a request; an in-flight beat is always absorbed.
// Ports   : clk/rst (sync, active-high); redirect_i/redirect_pc_i retarget the PC and flush;
//           inst_req/inst_addr/inst_addr_ok/inst_data_ok/inst_rdata form the sram-like bus;
//           inst{1,2}_o, inst{1,2}_addr_o, inst{1,2}_valid_o feed the buffer.
// Config  : define FETCH_PERF_CNT_EN to add perf_stall_cnt_o / perf_cancel_cnt_o
//           (saturating, cleared by rst).
module inst_fetch_pair
   import inst_fetch_pair_pkg::*;
#(
   parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
)
(
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]             perf_stall_cnt_o,
   output logic [31:0]             perf_cancel_cnt_o,
`endif
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    redirect_i,
   input  logic [INST_ADDR_W-1:0]  redirect_pc_i,
   input  logic                    buffer_full_i,
   output logic                    inst_req,
   output logic [INST_ADDR_W-1:0]  inst_addr,
   input  logic                    inst_addr_ok,
   input  logic                    inst_data_ok,
   input  logic [INST_BUS_W-1:0]   inst_rdata,
   output logic [INST_ADDR_W-1:0]  inst1_o,
   output logic [INST_ADDR_W-1:0]  inst2_o,
   output logic [INST_ADDR_W-1:0]  inst1_addr_o,
   output logic [INST_ADDR_W-1:0]  inst2_addr_o,
   output logic                    inst1_valid_o,
   output logic                    inst2_valid_o
);

   logic [1:0]              r_state;
   logic [1:0]              w_state_nxt;
   // PC is always word aligned, so only bits [31:2] are kept.
   logic [INST_ADDR_W-1:2]  r_pc;
   logic [INST_ADDR_W-1:2]  w_pc_nxt;
   logic                    w_can_fetch;
   logic                    w_beat_take;
   logic                    w_unused_pc_lsb;

   logic [INST_ADDR_W-1:0]  r_inst1;
   logic [INST_ADDR_W-1:0]  r_inst2;
   logic [INST_ADDR_W-1:0]  r_inst1_addr;
   logic [INST_ADDR_W-1:0]  r_inst2_addr;
   logic                    r_inst1_vld;
   logic                    r_inst2_vld;

   assign w_unused_pc_lsb = ^redirect_pc_i[1:0];

   assign w_can_fetch = !buffer_full_i && !redirect_i;
   // A returning beat is only written to the buffer if no redirect has flushed it.
   assign w_beat_take = (r_state == S_WAIT) && inst_data_ok && !redirect_i;

   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      case (r_state)
         S_IDLE: begin
            if (w_can_fetch) w_state_nxt = S_REQ;
         end
         S_REQ: begin
            // Redirect without addr_ok just retargets the pending request.
            if (inst_addr_ok) w_state_nxt = redirect_i ? S_CANCEL : S_WAIT;
         end
         S_WAIT: begin
            // With a same-cycle redirect w_can_fetch is low, so the beat is
            // dropped and we fall back to IDLE.
            if (inst_data_ok)    w_state_nxt = w_can_fetch ? S_REQ : S_IDLE;
            else if (redirect_i) w_state_nxt = S_CANCEL;
         end
         S_CANCEL: begin
            if (inst_data_ok) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase

      if (w_beat_take) w_pc_nxt = {r_pc[INST_ADDR_W-1:3] + 29'd1, 1'b0};
      if (redirect_i)  w_pc_nxt = redirect_pc_i[INST_ADDR_W-1:2];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_pc    <= RESET_PC[INST_ADDR_W-1:2];
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
      end
   end

   // Pair register: valids pulse for exactly one cycle per accepted beat.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inst1      <= '0;
         r_inst2      <= '0;
         r_inst1_addr <= '0;
         r_inst2_addr <= '0;
         r_inst1_vld  <= INVALID;
         r_inst2_vld  <= INVALID;
      end else begin
         r_inst1_vld <= INVALID;
         r_inst2_vld <= INVALID;
         if (w_beat_take) begin
            r_inst1      <= inst_rdata[31:0];
            r_inst2      <= inst_rdata[63:32];
            r_inst1_addr <= pair_base(r_pc);
            r_inst2_addr <= {r_pc[INST_ADDR_W-1:3], 3'b100};
            // Entering at the upper word of a pair: the lower word is not on the path.
            r_inst1_vld  <= !r_pc[2];
            r_inst2_vld  <= VALID;
         end
      end
   end

   assign inst_req      = (r_state == S_REQ);
   assign inst_addr     = pair_base(r_pc);
   assign inst1_o       = r_inst1;
   assign inst2_o       = r_inst2;
   assign inst1_addr_o  = r_inst1_addr;
   assign inst2_addr_o  = r_inst2_addr;
   assign inst1_valid_o = r_inst1_vld;
   assign inst2_valid_o = r_inst2_vld;

`ifdef FETCH_PERF_CNT_EN
   logic        w_beat_drop;
   logic [31:0] r_stall_cnt;
   logic [31:0] r_cancel_cnt;

   assign w_beat_drop = inst_data_ok &&
                        ((r_state == S_CANCEL) || ((r_state == S_WAIT) && redirect_i));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt  <= '0;
         r_cancel_cnt <= '0;
      end else begin
         if ((r_state == S_IDLE) && buffer_full_i && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 32'd1;
         if (w_beat_drop && (r_cancel_cnt != '1))
            r_cancel_cnt <= r_cancel_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt_o  = r_stall_cnt;
   assign perf_cancel_cnt_o = r_cancel_cnt;
`endif

endmodule

// File: tb/tb_inst_fetch_pair.sv
// Bench for inst_fetch_pair: directed scenarios with literal expectations, then
// randomized bus/redirect/back-pressure traffic against a transaction-level model.
module tb_inst_fetch_pair;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        buffer_full_i;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [63:0] inst_rdata;
   logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
   logic        inst1_valid_o, inst2_valid_o;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt_o, perf_cancel_cnt_o;
`endif

   inst_fetch_pair dut (
`ifdef FETCH_PERF_CNT_EN
      .perf_stall_cnt_o  (perf_stall_cnt_o),
      .perf_cancel_cnt_o (perf_cancel_cnt_o),
`endif
      .clk           (clk),
      .rst           (rst),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .buffer_full_i (buffer_full_i),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_addr_ok  (inst_addr_ok),
      .inst_data_ok  (inst_data_ok),
      .inst_rdata    (inst_rdata),
      .inst1_o       (inst1_o),
      .inst2_o       (inst2_o),
      .inst1_addr_o  (inst1_addr_o),
      .inst2_addr_o  (inst2_addr_o),
      .inst1_valid_o (inst1_valid_o),
      .inst2_valid_o (inst2_valid_o)
   );

   int checks = 0;
   int errors = 0;

   // Transaction-level model: fetch PC, the one outstanding request and whether
   // a redirect has made it stale, plus what the pair outputs must show next.
   logic [31:0] m_pc;
   logic [31:0] m_acc_addr;
   bit          m_out;
   bit          m_stale;
   logic        e_v1, e_v2;
   logic [31:0] e_i1, e_i2, e_a1, e_a2;
   bit          prev_hold;
   logic [31:0] prev_addr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare process: pair outputs against the model every cycle.
   always @(posedge clk) begin
      #2;
      chk("inst1_valid", {31'd0, inst1_valid_o}, {31'd0, e_v1});
      chk("inst2_valid", {31'd0, inst2_valid_o}, {31'd0, e_v2});
      if (e_v2) begin
         chk("inst1_addr", inst1_addr_o, e_a1);
         chk("inst2_addr", inst2_addr_o, e_a2);
         chk("inst1_data", inst1_o, e_i1);
         chk("inst2_data", inst2_o, e_i2);
      end
   end

   // Called at a negedge; applies reset for two rising edges.
   task automatic do_reset();
      rst = 1'b1; redirect_i = 1'b0; redirect_pc_i = '0; buffer_full_i = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;
      m_pc = 32'hBFC0_0000; m_out = 0; m_stale = 0; m_acc_addr = '0;
      e_v1 = 1'b0; e_v2 = 1'b0; prev_hold = 0; prev_addr = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // One cycle: check bus-side rules, drive inputs, advance the model, wait a cycle.
   // addr_ok is only offered to a visible request with nothing outstanding;
   // data_ok only while a beat is outstanding.
   task automatic step(input bit redir, input logic [31:0] rpc, input bit bf,
                       input bit aok, input bit dok);
      bit a, d;
      if (m_out) chk("single_outstanding", {31'd0, inst_req}, 32'd0);
      if (prev_hold) begin
         chk("req_held", {31'd0, inst_req}, 32'd1);
         chk("req_addr_stable", inst_addr, prev_addr);
      end
      a = aok && inst_req && !m_out;
      d = dok && m_out;
      redirect_i    = redir;
      redirect_pc_i = rpc;
      buffer_full_i = bf;
      inst_addr_ok  = a;
      inst_data_ok  = d;
      inst_rdata    = d ? {mem_word(m_acc_addr + 32'd4), mem_word(m_acc_addr)}
                        : {$urandom, $urandom};
      e_v1 = 1'b0;
      e_v2 = 1'b0;
      if (d) begin
         if (!m_stale && !redir) begin
            e_v2 = 1'b1;
            e_v1 = !m_pc[2];
            e_a1 = m_acc_addr;
            e_a2 = m_acc_addr + 32'd4;
            e_i1 = mem_word(m_acc_addr);
            e_i2 = mem_word(m_acc_addr + 32'd4);
            m_pc = m_acc_addr + 32'd8;
         end
         m_out = 0;
      end
      if (a) begin
         chk("req_addr", inst_addr, {m_pc[31:3], 3'b000});
         m_acc_addr = {m_pc[31:3], 3'b000};
         m_out      = 1;
         m_stale    = redir;
      end
      if (redir) begin
         if (m_out) m_stale = 1;
         m_pc = rpc;
      end
      prev_hold = inst_req && !a && !redir;
      prev_addr = inst_addr;
      @(negedge clk);
   endtask

   task automatic idle_step(input bit bf);
      step(1'b0, 32'd0, bf, 1'b0, 1'b0);
   endtask

   initial begin
      logic [31:0] rpc;
      rst = 1'b1;
      do_reset();

`ifdef FETCH_PERF_CNT_EN
      repeat (4) idle_step(1'b1);
      idle_step(1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h8000_0400, 1'b0, 1'b0, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("perf_stall_cnt", perf_stall_cnt_o, 32'd4);
      chk("perf_cancel_cnt", perf_cancel_cnt_o, 32'd1);
      do_reset();
      chk("perf_stall_rst", perf_stall_cnt_o, 32'd0);
`endif

      // Reset state
      chk("rst_req", {31'd0, inst_req}, 32'd0);
      chk("rst_v1", {31'd0, inst1_valid_o}, 32'd0);
      chk("rst_v2", {31'd0, inst2_valid_o}, 32'd0);
      chk("rst_inst1", inst1_o, 32'd0);
      chk("rst_addr2", inst2_addr_o, 32'd0);

      // First fetch from reset PC
      idle_step(1'b0);
      chk("t1_req", {31'd0, inst_req}, 32'd1);
      chk("t1_addr", inst_addr, 32'hBFC0_0000);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("t1_v1", {31'd0, inst1_valid_o}, 32'd1);
      chk("t1_v2", {31'd0, inst2_valid_o}, 32'd1);
      chk("t1_a1", inst1_addr_o, 32'hBFC0_0000);
      chk("t1_a2", inst2_addr_o, 32'hBFC0_0004);
      chk("t1_next_addr", inst_addr, 32'hBFC0_0008);

      // Redirect in WAIT, beat returns 3 cycles later and is dropped
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h8000_0014, 1'b0, 1'b0, 1'b0);
      idle_step(1'b0);
      idle_step(1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("t2_drop_v2", {31'd0, inst2_valid_o}, 32'd0);
      idle_step(1'b0);
      chk("t2_addr", inst_addr, 32'h8000_0010);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("t2_v1", {31'd0, inst1_valid_o}, 32'd0);
      chk("t2_v2", {31'd0, inst2_valid_o}, 32'd1);
      chk("t2_a2", inst2_addr_o, 32'h8000_0014);

      // Redirect together with data_ok
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b1, 32'h8000_0100, 1'b0, 1'b0, 1'b1);
      chk("t3_v2", {31'd0, inst2_valid_o}, 32'd0);
      idle_step(1'b0);
      chk("t3_addr", inst_addr, 32'h8000_0100);

      // Buffer full blocks the next launch
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         idle_step(1'b1);
         chk("t4_req_blocked", {31'd0, inst_req}, 32'd0);
      end
      idle_step(1'b0);
      chk("t4_req", {31'd0, inst_req}, 32'd1);
      chk("t4_addr", inst_addr, 32'h8000_0108);

      // addr_ok withheld: request stays put
      for (int i = 0; i < 5; i++) begin
         idle_step(1'b0);
         chk("t5_req", {31'd0, inst_req}, 32'd1);
         chk("t5_addr", inst_addr, 32'h8000_0108);
      end
      step(1'b1, 32'h8000_0204, 1'b0, 1'b0, 1'b0);
      chk("t5_retarget", inst_addr, 32'h8000_0200);
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      step(1'b0, 32'd0, 1'b0, 1'b0, 1'b1);
      chk("t5_v1", {31'd0, inst1_valid_o}, 32'd0);
      chk("t5_a1", inst1_addr_o, 32'h8000_0200);

      // Reset while a request is outstanding
      step(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
      do_reset();
      chk("t6_req", {31'd0, inst_req}, 32'd0);
      chk("t6_v2", {31'd0, inst2_valid_o}, 32'd0);
      idle_step(1'b0);
      chk("t6_addr", inst_addr, 32'hBFC0_0000);

      // Random traffic
      for (int i = 0; i < 4000; i++) begin
         rpc = 32'h8000_0000 | (32'($urandom_range(0, 1023)) << 2);
         step($urandom_range(0, 99) < 8, rpc, $urandom_range(0, 99) < 25,
              $urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
